// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
// Drives the register file write port from the writeback stage. It holds
// the MEM/WB pipeline register, extracts load data, and selects the
// writeback source. It also shares the single write port with results
// from the multi-cycle M-unit. Those results wait in a one-entry buffer
// until the pipeline leaves the port idle. If the pipeline keeps the port
// busy for too long, the buffer forces the port for one cycle.
module rf_writeback_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_regwrite,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wbsel,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic            wb_stall,
    input  logic            wb_flush,
    input  logic            md_valid,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_result,
    output logic            md_ready,
    output logic            stall_req,
    output logic [4:0]      reg_write,
    output logic [XLEN-1:0] write_data,
    output logic            writeenable,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    localparam int unsigned AW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    // MEM/WB pipeline register
    logic            r_valid;
    logic            r_regwrite;
    logic [4:0]      r_rd;
    logic [1:0]      r_wbsel;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_ldata;
    logic [XLEN-1:0] r_pc4;

    // M-unit hold buffer and arbitration state
    state_t          r_state;
    logic [AW-1:0]   r_age;
    logic [4:0]      r_buf_rd;
    logic [XLEN-1:0] r_buf_data;

    logic            w_md_ready;
    logic            w_stall_req;
    logic            w_accept;
    logic            w_p_req;
    logic [AW-1:0]   w_age_next;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_pipe_data;
    logic            w_we;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_data;

    // The buffer is empty only in S_EMPTY. Keeping md_ready low in S_WAIT
    // prevents a drain and a refill in the same cycle.
    assign w_md_ready  = (r_state == S_EMPTY) & rst;
    assign w_stall_req = (r_state == S_FORCE) & rst;
    // A result with md_rd=0 is accepted at the handshake but not stored.
    assign w_accept    = md_valid & w_md_ready & (md_rd != 5'd0);
    assign w_p_req     = r_valid & r_regwrite & (r_rd != 5'd0);
    assign w_age_next  = r_age + AW'(1);

    // MEM/WB register: reset clears, flush beats stall, stall or force holds
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_wbsel    <= '0;
            r_funct3   <= '0;
            r_alu      <= '0;
            r_ldata    <= '0;
            r_pc4      <= '0;
        end else if (wb_flush) begin
            r_valid <= 1'b0;
        end else if (!(wb_stall || w_stall_req)) begin
            r_valid    <= mem_valid;
            r_regwrite <= mem_regwrite;
            r_rd       <= mem_rd;
            r_wbsel    <= mem_wbsel;
            r_funct3   <= mem_funct3;
            r_alu      <= mem_alu_result;
            r_ldata    <= mem_load_data;
            r_pc4      <= mem_pc_plus4;
        end
    end

    // Arbitration FSM: the buffered M-unit result ages while the pipeline
    // keeps winning, then forces the port
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_EMPTY;
            r_age      <= '0;
            r_buf_rd   <= '0;
            r_buf_data <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state    <= S_WAIT;
                        r_age      <= '0;
                        r_buf_rd   <= md_rd;
                        r_buf_data <= md_result;
                    end
                end
                S_WAIT: begin
                    if (!w_p_req) begin
                        r_state <= S_EMPTY;
                    end else begin
                        r_age <= w_age_next;
                        if (w_age_next >= AW'(STARVE_LIMIT - 1)) begin
                            r_state <= S_FORCE;
                        end
                    end
                end
                S_FORCE: begin
                    r_state <= S_EMPTY;
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    // Load extraction: select byte/half by address offset, then extend
    always_comb begin
        w_byte = 8'h00;
        case (r_alu[1:0])
            2'd0:    w_byte = r_ldata[7:0];
            2'd1:    w_byte = r_ldata[15:8];
            2'd2:    w_byte = r_ldata[23:16];
            default: w_byte = r_ldata[31:24];
        endcase
        w_half = r_alu[1] ? r_ldata[31:16] : r_ldata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = r_ldata;
        endcase
    end

    // Writeback source select
    always_comb begin
        case (r_wbsel)
            2'b01:   w_pipe_data = w_load_data;
            2'b10:   w_pipe_data = r_pc4;
            default: w_pipe_data = r_alu;
        endcase
    end

    // Write port mux: FORCE first, then pipeline, then the waiting buffer
    always_comb begin
        w_we   = 1'b0;
        w_rd   = '0;
        w_data = '0;
        if (rst) begin
            if (r_state == S_FORCE) begin
                w_we   = 1'b1;
                w_rd   = r_buf_rd;
                w_data = r_buf_data;
            end else if (w_p_req) begin
                w_we   = 1'b1;
                w_rd   = r_rd;
                w_data = w_pipe_data;
            end else if (r_state == S_WAIT) begin
                w_we   = 1'b1;
                w_rd   = r_buf_rd;
                w_data = r_buf_data;
            end
        end
    end

    assign md_ready    = w_md_ready;
    assign stall_req   = w_stall_req;
    assign writeenable = w_we;
    assign reg_write   = w_rd;
    assign write_data  = w_data;
    assign fwd_valid   = w_we;
    assign fwd_rd      = w_rd;
    assign fwd_data    = w_data;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Testbench for rf_writeback_arbiter: a table of single-instruction
// writeback vectors plus hand-written multi-cycle sequences. Expected
// write-port values go into a queue when stimulus is driven and are popped
// after the capturing edge.
module tb_rf_writeback_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LIMIT = 4;

    logic            clk;
    logic            rst;
    logic            mem_valid;
    logic            mem_regwrite;
    logic [4:0]      mem_rd;
    logic [1:0]      mem_wbsel;
    logic [2:0]      mem_funct3;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_load_data;
    logic [XLEN-1:0] mem_pc_plus4;
    logic            wb_stall;
    logic            wb_flush;
    logic            md_valid;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_result;
    logic            md_ready;
    logic            stall_req;
    logic [4:0]      reg_write;
    logic [XLEN-1:0] write_data;
    logic            writeenable;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;

    rf_writeback_arbiter #(
        .XLEN        (XLEN),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_valid     (mem_valid),
        .mem_regwrite  (mem_regwrite),
        .mem_rd        (mem_rd),
        .mem_wbsel     (mem_wbsel),
        .mem_funct3    (mem_funct3),
        .mem_alu_result(mem_alu_result),
        .mem_load_data (mem_load_data),
        .mem_pc_plus4  (mem_pc_plus4),
        .wb_stall      (wb_stall),
        .wb_flush      (wb_flush),
        .md_valid      (md_valid),
        .md_rd         (md_rd),
        .md_result     (md_result),
        .md_ready      (md_ready),
        .stall_req     (stall_req),
        .reg_write     (reg_write),
        .write_data    (write_data),
        .writeenable   (writeenable),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } port_t;

    typedef struct {
        string       name;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  wbsel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc4;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    port_t sb[$];
    vec_t  vecs[12];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic vec_t mkv(input string nm, input logic rw, input logic [4:0] rd,
                                 input logic [1:0] ws, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] ld,
                                 input logic [31:0] pc4, input logic we,
                                 input logic [4:0] erd, input logic [31:0] ed);
        vec_t v;
        v.name = nm; v.rw = rw; v.rd = rd; v.wbsel = ws; v.f3 = f3;
        v.alu = alu; v.ld = ld; v.pc4 = pc4;
        v.exp_we = we; v.exp_rd = erd; v.exp_data = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_port(input logic we, input logic [4:0] rd, input logic [31:0] data);
        port_t e;
        e.we = we; e.rd = rd; e.data = data;
        sb.push_back(e);
    endtask

    task automatic check_port(input string nm);
        port_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got we=%0b rd=%0d data=0x%0h",
                     nm, writeenable, reg_write, write_data);
        end else begin
            e = sb.pop_front();
            chk({nm, ".port"}, {25'd0, writeenable, reg_write, write_data}, {25'd0, e});
            chk({nm, ".fwd"},  {25'd0, fwd_valid, fwd_rd, fwd_data},        {25'd0, e});
        end
    endtask

    task automatic drive_instr(input logic rw, input logic [4:0] rd, input logic [1:0] ws,
                               input logic [2:0] f3, input logic [31:0] alu,
                               input logic [31:0] ld, input logic [31:0] pc4);
        mem_valid      = 1'b1;
        mem_regwrite   = rw;
        mem_rd         = rd;
        mem_wbsel      = ws;
        mem_funct3     = f3;
        mem_alu_result = alu;
        mem_load_data  = ld;
        mem_pc_plus4   = pc4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with an M-unit offer and a pipeline instruction present
        rst = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
        md_valid = 1'b1; md_rd = 5'd7; md_result = 32'h1111_2222;
        drive_instr(1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 32'h0);
        tick();
        tick();
        chk("reset.we",      {63'd0, writeenable}, 64'd0);
        chk("reset.rd",      {59'd0, reg_write},   64'd0);
        chk("reset.data",    {32'd0, write_data},  64'd0);
        chk("reset.fwd",     {25'd0, fwd_valid, fwd_rd, fwd_data}, 64'd0);
        chk("reset.md_rdy",  {63'd0, md_ready},    64'd0);
        chk("reset.stall",   {63'd0, stall_req},   64'd0);
        rst = 1'b1; md_valid = 1'b0; mem_valid = 1'b0;
        #1;
        chk("release.md_rdy", {63'd0, md_ready},    64'd1);
        chk("release.we",     {63'd0, writeenable}, 64'd0);
        tick();

        // Single-instruction writeback vectors
        vecs[0]  = mkv("lb_off1",  1, 5'd3,  2'b01, 3'b000, 32'h0000_1001, 32'h8081_F2F3, 0, 1, 5'd3,  32'hFFFF_FFF2);
        vecs[1]  = mkv("lbu_off3", 1, 5'd3,  2'b01, 3'b100, 32'h0000_2003, 32'h8081_F2F3, 0, 1, 5'd3,  32'h0000_0080);
        vecs[2]  = mkv("lh_off2",  1, 5'd4,  2'b01, 3'b001, 32'h0000_0002, 32'h8081_F2F3, 0, 1, 5'd4,  32'hFFFF_8081);
        vecs[3]  = mkv("lhu_off0", 1, 5'd4,  2'b01, 3'b101, 32'h0000_0000, 32'h8081_F2F3, 0, 1, 5'd4,  32'h0000_F2F3);
        vecs[4]  = mkv("lw",       1, 5'd8,  2'b01, 3'b010, 32'h0000_0004, 32'h8081_F2F3, 0, 1, 5'd8,  32'h8081_F2F3);
        vecs[5]  = mkv("lh_off3",  1, 5'd4,  2'b01, 3'b001, 32'h0000_0003, 32'h8081_F2F3, 0, 1, 5'd4,  32'hFFFF_8081);
        vecs[6]  = mkv("lb_pos",   1, 5'd6,  2'b01, 3'b000, 32'h0000_0000, 32'h1234_567F, 0, 1, 5'd6,  32'h0000_007F);
        vecs[7]  = mkv("pc4_x1",   1, 5'd1,  2'b10, 3'b000, 32'h0000_0999, 32'h0,         32'h0000_0104, 1, 5'd1, 32'h0000_0104);
        vecs[8]  = mkv("pc4_x0",   1, 5'd0,  2'b10, 3'b000, 32'h0000_0999, 32'h0,         32'h0000_0104, 0, 5'd0, 32'h0);
        vecs[9]  = mkv("alu_00",   1, 5'd31, 2'b00, 3'b000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h4, 1, 5'd31, 32'h1234_5678);
        vecs[10] = mkv("alu_11",   1, 5'd2,  2'b11, 3'b000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h4, 1, 5'd2,  32'hCAFE_F00D);
        vecs[11] = mkv("no_rw",    0, 5'd4,  2'b00, 3'b000, 32'h0000_0044, 32'h0,         32'h0,  0, 5'd0, 32'h0);
        foreach (vecs[i]) begin
            drive_instr(vecs[i].rw, vecs[i].rd, vecs[i].wbsel, vecs[i].f3,
                        vecs[i].alu, vecs[i].ld, vecs[i].pc4);
            expect_port(vecs[i].exp_we, vecs[i].exp_rd, vecs[i].exp_data);
            tick();
            check_port(vecs[i].name);
        end
        mem_valid = 1'b0;
        expect_port(1'b0, 5'd0, 32'h0);
        tick();
        check_port("idle");

        // Idle port: M-unit result written the next cycle
        md_valid = 1'b1; md_rd = 5'd7; md_result = 32'hDEAD_BEEF;
        chk("md.ready_before", {63'd0, md_ready}, 64'd1);
        expect_port(1'b1, 5'd7, 32'hDEAD_BEEF);
        tick();
        md_valid = 1'b0;
        check_port("md.idle_write");
        chk("md.ready_busy", {63'd0, md_ready}, 64'd0);
        expect_port(1'b0, 5'd0, 32'h0);
        tick();
        check_port("md.drained");
        chk("md.ready_after", {63'd0, md_ready}, 64'd1);

        // md_rd=0 is accepted and discarded
        md_valid = 1'b1; md_rd = 5'd0; md_result = 32'h5555_5555;
        expect_port(1'b0, 5'd0, 32'h0);
        tick();
        md_valid = 1'b0;
        check_port("md.x0");
        chk("md.x0_ready", {63'd0, md_ready}, 64'd1);

        // Buffer waits one cycle behind the pipeline, then drains on idle
        md_valid = 1'b1; md_rd = 5'd12; md_result = 32'h0000_0C0C;
        drive_instr(1'b1, 5'd13, 2'b00, 3'b000, 32'h0000_0D0D, 32'h0, 32'h0);
        expect_port(1'b1, 5'd13, 32'h0000_0D0D);
        tick();
        md_valid = 1'b0; mem_valid = 1'b0;
        check_port("wait.pipe_first");
        expect_port(1'b1, 5'd12, 32'h0000_0C0C);
        tick();
        check_port("wait.buf_drain");
        expect_port(1'b0, 5'd0, 32'h0);
        tick();
        check_port("wait.empty");

        // Starvation: continuous pipeline writes, then FORCE
        md_valid = 1'b1; md_rd = 5'd9; md_result = 32'h0000_900D;
        for (int k = 0; k < LIMIT; k++) begin
            drive_instr(1'b1, 5'(10 + k), 2'b00, 3'b000, 32'hA000_0000 + 32'(k), 32'h0, 32'h0);
            if (k < LIMIT - 1) expect_port(1'b1, 5'(10 + k), 32'hA000_0000 + 32'(k));
            else               expect_port(1'b1, 5'd9, 32'h0000_900D);
            tick();
            md_valid = 1'b0;
            check_port($sformatf("starve.%0d", k));
            chk($sformatf("starve.stall%0d", k), {63'd0, stall_req}, {63'd0, (k == LIMIT - 1)});
        end
        drive_instr(1'b1, 5'd20, 2'b00, 3'b000, 32'h0000_2020, 32'h0, 32'h0);
        expect_port(1'b1, 5'(10 + LIMIT - 1), 32'hA000_0000 + 32'(LIMIT - 1));
        tick();
        check_port("starve.deferred");
        chk("starve.stall_off", {63'd0, stall_req}, 64'd0);
        expect_port(1'b1, 5'd20, 32'h0000_2020);
        tick();
        check_port("starve.next");
        mem_valid = 1'b0;
        expect_port(1'b0, 5'd0, 32'h0);
        tick();
        check_port("starve.idle");

        // Stall holds the stage; flush with stall invalidates it
        drive_instr(1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 32'h0);
        expect_port(1'b1, 5'd5, 32'h0000_0055);
        tick();
        check_port("stall.first");
        wb_stall = 1'b1;
        drive_instr(1'b1, 5'd6, 2'b00, 3'b000, 32'h0000_0066, 32'h0, 32'h0);
        expect_port(1'b1, 5'd5, 32'h0000_0055);
        tick();
        check_port("stall.hold1");
        expect_port(1'b1, 5'd5, 32'h0000_0055);
        tick();
        check_port("stall.hold2");
        wb_flush = 1'b1;
        expect_port(1'b0, 5'd0, 32'h0);
        tick();
        check_port("flush.over_stall");
        wb_flush = 1'b0; wb_stall = 1'b0; mem_valid = 1'b0;
        expect_port(1'b0, 5'd0, 32'h0);
        tick();
        check_port("flush.idle");

        // Reset while a result is waiting discards it
        md_valid = 1'b1; md_rd = 5'd21; md_result = 32'h0000_2121;
        drive_instr(1'b1, 5'd22, 2'b00, 3'b000, 32'h0000_2222, 32'h0, 32'h0);
        expect_port(1'b1, 5'd22, 32'h0000_2222);
        tick();
        check_port("rstwait.pipe");
        md_valid = 1'b0; mem_valid = 1'b0; rst = 1'b0;
        #1;
        chk("rstwait.we_low", {63'd0, writeenable}, 64'd0);
        chk("rstwait.ready_low", {63'd0, md_ready}, 64'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("rstwait.ready", {63'd0, md_ready}, 64'd1);
        expect_port(1'b0, 5'd0, 32'h0);
        tick();
        check_port("rstwait.discarded");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
